// File: rtl/csr_reg_file.sv
// Machine-mode CSR file: one combinational read/modify port, trap/mret state updates from commit.
// Optional cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_reg_file #(
    parameter int XLEN    = 64,
    parameter int HART_ID = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    input  logic            retire_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic [2:0]      irq_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_glob_o
);
    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;
    localparam logic [1:0]  OP_RC = 2'b11;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VAL =
        {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-2){1'b0}}} | XLEN'(32'h1100);
    localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_en_q, mie_en_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;

    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    logic            known;
    logic            is_write;
    logic            wr_en;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    always_comb begin
        known   = 1'b1;
        old_val = '0;
        case (req_addr)
            A_MSTATUS: begin
                old_val[12:11] = 2'b11;
                old_val[7]     = mstatus_mpie_q;
                old_val[3]     = mstatus_mie_q;
            end
            A_MISA:     old_val = MISA_VAL;
            A_MIE: begin
                old_val[11] = mie_en_q[2];
                old_val[7]  = mie_en_q[1];
                old_val[3]  = mie_en_q[0];
            end
            A_MTVEC:    old_val = mtvec_q;
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MTVAL:    old_val = mtval_q;
            A_MIP: begin
                old_val[11] = irq_i[2];
                old_val[7]  = irq_i[1];
                old_val[3]  = irq_i[0];
            end
            A_MHARTID:  old_val = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
            A_MCYCLE, A_CYCLE:     old_val = mcycle_q;
            A_MINSTRET, A_INSTRET: old_val = minstret_q;
`endif
            default:    known = 1'b0;
        endcase
    end

    // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
    assign is_write  = req_valid && ((req_op == OP_RW) || ((req_op != 2'b00) && (req_wdata != '0)));
    assign illegal_o = req_valid && (!known || (is_write && (req_addr[11:10] == 2'b11)));
    assign wr_en     = is_write && !illegal_o;
    assign rdata_o   = old_val;

    always_comb begin
        case (req_op)
            OP_RW:   new_val = req_wdata;
            OP_RS:   new_val = old_val | req_wdata;
            OP_RC:   new_val = old_val & ~req_wdata;
            default: new_val = old_val;
        endcase
    end

    // Later assignments override earlier ones: CSR write < mret < trap.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d       = mcycle_q + XLEN'(1);
        minstret_d     = minstret_q + XLEN'(retire_i);
`endif
        if (wr_en) begin
            case (req_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = new_val[3];
                    mstatus_mpie_d = new_val[7];
                end
                A_MIE:      mie_en_d   = {new_val[11], new_val[7], new_val[3]};
                A_MTVEC:    mtvec_d    = new_val[1] ? (new_val & LOW2_MASK) : new_val;
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = new_val & LOW2_MASK;
                A_MCAUSE:   mcause_d   = new_val;
                A_MTVAL:    mtval_d    = new_val;
`ifdef CSR_COUNTERS_EN
                A_MCYCLE:   mcycle_d   = new_val;
                A_MINSTRET: minstret_d = new_val;
`endif
                default: ;
            endcase
        end
        if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (trap_valid_i) begin
            mepc_d         = trap_pc_i & LOW2_MASK;
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= '0;
            minstret_q     <= '0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
`endif
        end
    end

    assign mtvec_o    = mtvec_q;
    assign mepc_o     = mepc_q;
    assign mie_glob_o = mstatus_mie_q;
endmodule

// File: tb/tb_csr_reg_file.sv
// Bench for csr_reg_file: directed register scenarios, then random traffic against a register-level model.
// Counter checks follow whether CSR_COUNTERS_EN is defined for the build.
module tb_csr_reg_file;
    localparam int XLEN    = 64;
    localparam int HART_ID = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [11:0]     req_addr;
    logic [63:0]     req_wdata;
    logic [63:0]     rdata_o;
    logic            illegal_o;
    logic            retire_i;
    logic            trap_valid_i;
    logic [63:0]     trap_pc_i, trap_cause_i, trap_tval_i;
    logic            mret_i;
    logic [2:0]      irq_i;
    logic [63:0]     mtvec_o, mepc_o;
    logic            mie_glob_o;

    csr_reg_file #(.XLEN(XLEN), .HART_ID(HART_ID)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata_o(rdata_o), .illegal_o(illegal_o),
        .retire_i(retire_i),
        .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
        .trap_cause_i(trap_cause_i), .trap_tval_i(trap_tval_i),
        .mret_i(mret_i), .irq_i(irq_i),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_glob_o(mie_glob_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state, kept as architectural register contents.
    bit          m_mie, m_mpie;
    logic [63:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_read(input logic [11:0] a, output bit k, output logic [63:0] v);
        k = 1'b1;
        v = '0;
        case (a)
            12'h300: begin v = 64'h1800; v[3] = m_mie; v[7] = m_mpie; end
            12'h301: v = 64'h8000_0000_0000_1100;
            12'h304: v = m_mie_reg;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: begin v[3] = irq_i[0]; v[7] = irq_i[1]; v[11] = irq_i[2]; end
            12'hF14: v = 64'(HART_ID);
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: v = m_mcycle;
            12'hB02, 12'hC02: v = m_minstret;
`endif
            default: k = 1'b0;
        endcase
    endfunction

    function automatic bit model_writes();
        return req_valid && (req_op == 2'b01 || (req_op != 2'b00 && req_wdata != 0));
    endfunction

    function automatic bit model_illegal();
        bit k;
        logic [63:0] v;
        model_read(req_addr, k, v);
        return req_valid && (!k || (model_writes() && req_addr[11:10] == 2'b11));
    endfunction

    task automatic model_update();
        bit k, o_mie, o_mpie;
        logic [63:0] old, nv;
        if (!rstn) begin
            m_mie = 0; m_mpie = 0;
            m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
            return;
        end
        o_mie = m_mie;
        o_mpie = m_mpie;
        model_read(req_addr, k, old);
        case (req_op)
            2'b01:   nv = req_wdata;
            2'b10:   nv = old | req_wdata;
            default: nv = old & ~req_wdata;
        endcase
        m_mcycle = m_mcycle + 1;
        if (retire_i) m_minstret = m_minstret + 1;
        if (model_writes() && !model_illegal()) begin
            case (req_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg = nv & 64'h888;
                12'h305: m_mtvec = (nv[1:0] >= 2) ? (nv & ~64'd3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~64'd3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: m_mcycle = nv;
                12'hB02: m_minstret = nv;
                default: ;
            endcase
        end
        if (mret_i) begin m_mie = o_mpie; m_mpie = 1; end
        if (trap_valid_i) begin
            m_mepc = trap_pc_i & ~64'd3;
            m_mcause = trap_cause_i;
            m_mtval = trap_tval_i;
            m_mpie = o_mie;
            m_mie = 0;
        end
    endtask

    // Called just after a posedge; checks combinational outputs mid-cycle, then clocks once.
    task automatic step();
        bit k;
        logic [63:0] v;
        @(negedge clk);
        model_read(req_addr, k, v);
        check_val("illegal", 64'(illegal_o), 64'(model_illegal()));
        if (k) check_val("rdata", rdata_o, v);
        check_val("mtvec_o", mtvec_o, m_mtvec);
        check_val("mepc_o", mepc_o, m_mepc);
        check_val("mie_glob", 64'(mie_glob_o), 64'(m_mie));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rstn = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
        retire_i = 0; trap_valid_i = 0; trap_pc_i = 0; trap_cause_i = 0;
        trap_tval_i = 0; mret_i = 0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        idle();
        req_valid = 1; req_addr = a;
        #1;
        check_val(tag, rdata_o, exp);
        step();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
        idle();
        req_valid = 1; req_op = op; req_addr = a; req_wdata = d;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 64'h55;
        trap_valid_i = 1; trap_pc_i = 64'h44; mret_i = 1; retire_i = 1;
        step();
        idle();
    endtask

    logic [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB02,
                                    12'hC00, 12'hC02, 12'h7FF, 12'h300};

    initial begin
        irq_i = 0;
        idle();
        rstn = 0;
        step();
        do_reset();

        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("mhartid", 12'hF14, 64'(HART_ID));
        rd("misa", 12'h301, 64'h8000_0000_0000_1100);

        wr(2'b01, 12'h340, 64'hDEADBEEF);
        rd("scratch_rw", 12'h340, 64'hDEADBEEF);
        wr(2'b10, 12'h340, 64'hF0);
        rd("scratch_rs", 12'h340, 64'hDEADBEFF);
        wr(2'b11, 12'h340, 64'hFF);
        rd("scratch_rc", 12'h340, 64'hDEADBE00);

        wr(2'b01, 12'h305, 64'h1003);
        rd("mtvec_mode", 12'h305, 64'h1000);
        wr(2'b01, 12'h341, 64'h8000_0007);
        rd("mepc_align", 12'h341, 64'h8000_0004);

        idle(); req_valid = 1; req_op = 2'b01; req_addr = 12'hC00; req_wdata = 64'h5;
        #1 check_val("ill_c00", 64'(illegal_o), 64'd1);
        step();
        idle(); req_valid = 1; req_op = 2'b01; req_addr = 12'h7FF; req_wdata = 64'h5;
        #1 check_val("ill_7ff", 64'(illegal_o), 64'd1);
        step();
        rd("no_change", 12'h340, 64'hDEADBE00);

        wr(2'b10, 12'h300, 64'h8);
        check_val("mie_set", 64'(mie_glob_o), 64'd1);
        idle(); trap_valid_i = 1; trap_pc_i = 64'h8000_0010; trap_cause_i = 2; trap_tval_i = 64'h77;
        step();
        idle();
        check_val("trap_mepc", mepc_o, 64'h8000_0010);
        rd("trap_mcause", 12'h342, 64'd2);
        rd("trap_mstatus", 12'h300, 64'h1880);
        idle(); mret_i = 1;
        step();
        rd("mret_mstatus", 12'h300, 64'h1888);

        idle(); req_valid = 1; req_op = 2'b01; req_addr = 12'h341; req_wdata = 64'h1234;
        trap_valid_i = 1; trap_pc_i = 64'h4000_0022;
        step();
        idle();
        check_val("trap_wins", mepc_o, 64'h4000_0020);

        irq_i = 3'b101;
        rd("mip", 12'h344, 64'h808);
        idle(); req_valid = 1; req_op = 2'b01; req_addr = 12'h344; req_wdata = 0;
        #1 check_val("mip_wr_legal", 64'(illegal_o), 64'd0);
        step();
        rd("mip_after_wr", 12'h344, 64'h808);
        irq_i = 0;

`ifdef CSR_COUNTERS_EN
        do_reset();
        repeat (10) begin idle(); step(); end
        rd("mcycle10", 12'hB00, 64'd10);
        idle();
        repeat (3) begin idle(); retire_i = 1; step(); idle(); step(); end
        rd("instret3", 12'hC02, 64'd3);
        wr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        rd("mcycle_wrap", 12'hB00, 64'd0);
`else
        idle(); req_valid = 1; req_addr = 12'hB00;
        #1 check_val("no_counter", 64'(illegal_o), 64'd1);
        step();
`endif

        for (int i = 0; i < 800; i++) begin
            idle();
            rstn         = ($urandom_range(0, 99) != 0);
            req_valid    = ($urandom_range(0, 3) != 0);
            req_op       = 2'($urandom_range(0, 3));
            req_addr     = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 15)];
            req_wdata    = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            retire_i     = 1'($urandom);
            trap_valid_i = ($urandom_range(0, 15) == 0);
            trap_pc_i    = {$urandom, $urandom};
            trap_cause_i = 64'($urandom_range(0, 15));
            trap_tval_i  = {$urandom, $urandom};
            mret_i       = ($urandom_range(0, 7) == 0);
            irq_i        = 3'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
